tiled_framebuffer_multibuf: RTL and testbench
=============================================

Name: tiled_framebuffer_multibuf

Overview:
Multi-buffered successor to the tile-organised framebuffer: NUM_BUFFERS tile-interleaved pixel surfaces in one clock domain. The renderer writes whole tiles into the back buffer through a valid/ready port, and the display scanout reads single pixels from the front buffer. A swap handshake rotates the buffers. An optional clear engine wipes the new back buffer after each swap.

Parameters:
RESOLUTION_X, 400, pixels per line; multiple of TILE_WIDTH
RESOLUTION_Y, 300, lines; multiple of TILE_HEIGHT
PXL_BITS, 8, bits per pixel
TILE_WIDTH, 4, tile width in pixels; power of 2
TILE_HEIGHT, 4, tile height in pixels; power of 2
NUM_BUFFERS, 2, number of surfaces, 2..4
CLEAR_VALUE, 0, pixel value written by the clear engine (PXL_BITS wide)
Derived: PXL_PER_TILE = TILE_WIDTH*TILE_HEIGHT; TILE_COUNT = (RESOLUTION_X/TILE_WIDTH)*(RESOLUTION_Y/TILE_HEIGHT); TW = $clog2(TILE_COUNT)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high
wr_valid  in  1  tile write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_tile_index  in  TW  tile number, row-major over tiles
wr_pxl_data  in  PXL_PER_TILE*PXL_BITS  pixel p at bits [p*PXL_BITS +: PXL_BITS]; p = offset_y*TILE_WIDTH+offset_x
wr_mask  in  PXL_PER_TILE  per-pixel write enable
wr_oob  out  1  sticky: a write with wr_tile_index>=TILE_COUNT was accepted
rd_en  in  1  pixel read request
rd_pxl_x  in  $clog2(RESOLUTION_X)  pixel column
rd_pxl_y  in  $clog2(RESOLUTION_Y)  pixel row
rd_valid  out  1  rd_pxl_value valid
rd_pxl_value  out  PXL_BITS  read pixel
swap_req  in  1  request buffer rotation
swap_ready  out  1  swap accepted when swap_req&swap_ready
swap_done  out  1  one-cycle pulse: new back buffer is writable
front_idx  out  $clog2(NUM_BUFFERS)  surface currently scanned out
swap_count  out  16  number of accepted swaps, wraps at 2^16

Behaviour:
- Reset: front_idx=0, back_idx=1, state IDLE. Outputs: wr_ready=0 during reset, then 1 from the first cycle after; rd_valid=0, rd_pxl_value=0, swap_done=0, wr_oob=0, swap_count=0. Memory contents are not reset.
- Storage: PXL_PER_TILE banks. Each bank depth is NUM_BUFFERS*TILE_COUNT at address buf*TILE_COUNT+tile, with one pixel per bank entry. Pixel (x,y) sits in bank (y%TILE_HEIGHT)*TILE_WIDTH+(x%TILE_WIDTH) at tile (y/TILE_HEIGHT)*(RESOLUTION_X/TILE_WIDTH)+x/TILE_WIDTH.
- Write: wr_ready=(state==IDLE).
  - On accept, each pixel with wr_mask bit set is written to back_idx at wr_tile_index; the write commits on that edge.
  - If wr_tile_index>=TILE_COUNT, the write is dropped and wr_oob is set; wr_oob clears only on reset.
- Read: latency 1.
  - rd_en at cycle N gives rd_valid=1 and rd_pxl_value at N+1.
  - Otherwise rd_valid=0 and rd_pxl_value holds its last value.
  - The read uses the front_idx value present at cycle N, so a swap in the same cycle does not affect it.
  - If x>=RESOLUTION_X or y>=RESOLUTION_Y, rd_pxl_value=0 and rd_valid still asserts.
- Reads are independent of state and never stall.
- Swap: swap_ready=(state==IDLE). On accept, using the pre-swap back_idx:
  - front_idx<=back_idx; back_idx<=(back_idx+1)%NUM_BUFFERS; swap_count++.
  - Result: front always holds the most recently completed render.
- Simultaneous wr accept and swap accept: the write lands in the pre-swap back buffer, i.e. the new front.
- States: IDLE, CLEAR (only with the optional feature).
  - Without the feature: swap_done pulses at accept+1; state stays IDLE.
- Reset mid-CLEAR: the clear is aborted, state returns to IDLE, and the partially cleared buffer is left as-is.

Optional Feature:
FB_AUTO_CLEAR_EN
- Defined: on swap accept, go IDLE->CLEAR.
  - clr_tile counts 0..TILE_COUNT-1, one tile per cycle; all PXL_PER_TILE pixels of new back_idx are set to CLEAR_VALUE.
  - After the tile TILE_COUNT-1 write, go to IDLE and pulse swap_done (accept+TILE_COUNT+1).
  - wr_ready=swap_ready=0 throughout CLEAR; reads continue from front.
- Undefined: no CLEAR state and no clear counter; swap_done at accept+1; the back buffer keeps stale content.

Test Plan:
- Write tile 0, mask 0xFFFF, data pixel p=p+1; swap; read (0..3,0..3) -> after swap, rd_pxl_value(x,y)=4y+x+1, one cycle after rd_en.
- Write tile 101 (x 4..7, y 4..7), mask 0x0001, data 0xAA; swap; read (4,4)=0xAA, read (5,4) unchanged.
- Read (400,0) and (0,300) -> rd_valid=1, value 0. Write tile 7500 -> dropped, wr_oob=1 until reset.
- NUM_BUFFERS=3: three swaps -> front_idx 1,2,0, swap_count 3. Issue a read in the same cycle as a swap -> data comes from the old front.
- FB_AUTO_CLEAR_EN, CLEAR_VALUE=0x3C: fill back with 0xFF, swap, swap again -> swap_done at accept+7501, wr_ready=0 during CLEAR, all reads of the cleared buffer after the next swap=0x3C. Without the macro, swap_done at accept+1.
- Assert reset 50 cycles into CLEAR -> state IDLE, wr_ready=1 after deassert, front_idx=0, swap_count=0, no swap_done pulse.

Source files
------------

// File: rtl/tiled_framebuffer_multibuf.sv
// Multi-buffered tile-organised framebuffer: tile writes to back, pixel reads from front.
// Ports: clk/reset; wr_* tile write (valid/ready, mask, sticky wr_oob); rd_* pixel read
// (1-cycle latency); swap_req/swap_ready/swap_done rotation handshake; front_idx, swap_count.
// Optional macro FB_AUTO_CLEAR_EN: after each swap, wipe new back buffer to CLEAR_VALUE.
module tiled_framebuffer_multibuf #(
  parameter int RESOLUTION_X = 400,
  parameter int RESOLUTION_Y = 300,
  parameter int PXL_BITS = 8,
  parameter int TILE_WIDTH = 4,
  parameter int TILE_HEIGHT = 4,
  parameter int NUM_BUFFERS = 2,
  parameter logic [PXL_BITS-1:0] CLEAR_VALUE = '0,
  localparam int PXL_PER_TILE = TILE_WIDTH * TILE_HEIGHT,
  localparam int TILE_COUNT =
    (RESOLUTION_X / TILE_WIDTH) * (RESOLUTION_Y / TILE_HEIGHT),
  localparam int TW = $clog2(TILE_COUNT),
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y),
  localparam int FW = $clog2(NUM_BUFFERS)
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [TW-1:0] wr_tile_index,
  input  logic [PXL_PER_TILE*PXL_BITS-1:0] wr_pxl_data,
  input  logic [PXL_PER_TILE-1:0] wr_mask,
  output logic wr_oob,
  input  logic rd_en,
  input  logic [XW-1:0] rd_pxl_x,
  input  logic [YW-1:0] rd_pxl_y,
  output logic rd_valid,
  output logic [PXL_BITS-1:0] rd_pxl_value,
  input  logic swap_req,
  output logic swap_ready,
  output logic swap_done,
  output logic [FW-1:0] front_idx,
  output logic [15:0] swap_count
);

  localparam int TILES_X = RESOLUTION_X / TILE_WIDTH;
  localparam int DEPTH = NUM_BUFFERS * TILE_COUNT;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(PXL_PER_TILE);

  logic [PXL_BITS-1:0] mem [PXL_PER_TILE][DEPTH];

  logic [FW-1:0] back_idx;
  logic alive;
  logic idle;
  logic clearing;
  logic done_set;
  logic wr_fire;
  logic wr_bad;
  logic swap_fire;
  logic [TW-1:0] w_tile;
  logic [AW-1:0] w_addr;
  logic rd_in_range;
  logic [BW-1:0] rd_bank;
  logic [TW-1:0] rd_tile;
  logic [AW-1:0] rd_addr;

  function automatic logic [AW-1:0] addr_of(
    input logic [FW-1:0] b,
    input logic [TW-1:0] t
  );
    return AW'(b) * AW'(TILE_COUNT) + AW'(t);
  endfunction

`ifdef FB_AUTO_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  state_t state_nx;
  logic [TW-1:0] clr_tile;
  logic clr_last;

  assign clr_last = clr_tile == TW'(TILE_COUNT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      clr_tile <= '0;
    end else begin
      state <= state_nx;
      if (swap_fire)
        clr_tile <= '0;
      else if (state == CLEAR)
        clr_tile <= clr_tile + TW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (swap_fire) state_nx = CLEAR;
      CLEAR: if (clr_last) state_nx = IDLE;
    endcase
  end

  always_comb begin
    idle = alive && (state == IDLE);
    clearing = (state == CLEAR);
    w_tile = clearing ? clr_tile : wr_tile_index;
    done_set = clearing && clr_last;
  end
`else
  always_comb begin
    idle = alive;
    clearing = 1'b0;
    w_tile = wr_tile_index;
    done_set = swap_fire;
  end
`endif

  assign wr_ready = idle;
  assign swap_ready = idle;
  assign wr_fire = wr_valid && wr_ready;
  assign swap_fire = swap_req && swap_ready;
  assign wr_bad = 32'(wr_tile_index) >= TILE_COUNT;
  assign w_addr = addr_of(back_idx, w_tile);

  always_comb begin
    rd_in_range = (32'(rd_pxl_x) < RESOLUTION_X) &&
                  (32'(rd_pxl_y) < RESOLUTION_Y);
    rd_bank = BW'((32'(rd_pxl_y) % TILE_HEIGHT) * TILE_WIDTH +
                  32'(rd_pxl_x) % TILE_WIDTH);
    rd_tile = TW'((32'(rd_pxl_y) / TILE_HEIGHT) * TILES_X +
                  32'(rd_pxl_x) / TILE_WIDTH);
    rd_addr = addr_of(front_idx, rd_in_range ? rd_tile : '0);
  end

  // Pixel storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PXL_PER_TILE; p++) begin
      if (clearing)
        mem[p][w_addr] <= CLEAR_VALUE;
      else if (wr_fire && !wr_bad && wr_mask[p])
        mem[p][w_addr] <= wr_pxl_data[p*PXL_BITS +: PXL_BITS];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive <= 1'b0;
      front_idx <= '0;
      back_idx <= FW'(1);
      swap_count <= '0;
      wr_oob <= 1'b0;
      rd_valid <= 1'b0;
      rd_pxl_value <= '0;
      swap_done <= 1'b0;
    end else begin
      alive <= 1'b1;
      rd_valid <= rd_en;
      if (rd_en)
        rd_pxl_value <= rd_in_range ? mem[rd_bank][rd_addr] : '0;
      if (wr_fire && wr_bad)
        wr_oob <= 1'b1;
      if (swap_fire) begin
        front_idx <= back_idx;
        back_idx <= (back_idx == FW'(NUM_BUFFERS - 1)) ?
                    '0 : back_idx + FW'(1);
        swap_count <= swap_count + 16'd1;
      end
      swap_done <= done_set;
    end
  end

endmodule

// File: tb/tb_tiled_framebuffer_multibuf.sv
// Scoreboard bench for tiled_framebuffer_multibuf with a pixel-level surface model.
// Driver pushes expectations per cycle; a negedge monitor pops and compares.
module tb_tiled_framebuffer_multibuf;

  localparam int RX = 400;
  localparam int RY = 300;
  localparam int NB = 3;
  localparam int TX = 100;
  localparam int TC = 7500;
  localparam logic [7:0] CV = 8'h3C;
`ifdef FB_AUTO_CLEAR_EN
  localparam int LAT = TC + 1;
  localparam bit AC = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit AC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [12:0] wr_tile_index = '0;
  logic [127:0] wr_pxl_data = '0;
  logic [15:0] wr_mask = '0;
  logic wr_oob;
  logic rd_en = 1'b0;
  logic [8:0] rd_pxl_x = '0;
  logic [8:0] rd_pxl_y = '0;
  logic rd_valid;
  logic [7:0] rd_pxl_value;
  logic swap_req = 1'b0;
  logic swap_ready;
  logic swap_done;
  logic [1:0] front_idx;
  logic [15:0] swap_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tiled_framebuffer_multibuf #(
    .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PXL_BITS(8),
    .TILE_WIDTH(4), .TILE_HEIGHT(4), .NUM_BUFFERS(NB),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_tile_index(wr_tile_index), .wr_pxl_data(wr_pxl_data),
    .wr_mask(wr_mask), .wr_oob(wr_oob),
    .rd_en(rd_en), .rd_pxl_x(rd_pxl_x), .rd_pxl_y(rd_pxl_y),
    .rd_valid(rd_valid), .rd_pxl_value(rd_pxl_value),
    .swap_req(swap_req), .swap_ready(swap_ready),
    .swap_done(swap_done), .front_idx(front_idx),
    .swap_count(swap_count)
  );

  typedef struct {
    int due;
    bit rd;
    bit care;
    logic [7:0] val;
    int front;
    int cnt;
    bit oob;
    bit rdy;
  } exp_t;

  exp_t sb[$];
  int sd_q[$];
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] rmem [NB][RY][RX];
  bit rknown [NB][RY][RX];
  int m_front = 0;
  int m_back = 1;
  int m_count = 0;
  bit m_oob = 1'b0;
  int busy_until = 0;

  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
    end
  endtask

  task automatic model_write(input int t, input logic [127:0] d,
                             input logic [15:0] m);
    int x, y;
    for (int p = 0; p < 16; p++) begin
      if (m[p]) begin
        x = (t % TX) * 4 + p % 4;
        y = (t / TX) * 4 + p / 4;
        rmem[m_back][y][x] = d[p*8 +: 8];
        rknown[m_back][y][x] = 1'b1;
      end
    end
  endtask

  task automatic model_clear(input int b);
    for (int y = 0; y < RY; y++)
      for (int x = 0; x < RX; x++) begin
        rmem[b][y][x] = CV;
        rknown[b][y][x] = 1'b1;
      end
  endtask

  task automatic step(input bit do_wr, input int tile,
                      input logic [127:0] data, input logic [15:0] mask,
                      input bit do_rd, input int x, input int y,
                      input bit do_sw);
    exp_t rec;
    bit rdyc;
    @(negedge clk);
    wr_valid = do_wr;
    wr_tile_index = 13'(tile);
    wr_pxl_data = data;
    wr_mask = mask;
    rd_en = do_rd;
    rd_pxl_x = 9'(x);
    rd_pxl_y = 9'(y);
    swap_req = do_sw;
    rdyc = cyc > busy_until;
    rec.due = cyc + 1;
    rec.rd = do_rd;
    rec.care = 1'b0;
    rec.val = '0;
    if (do_rd) begin
      if (x >= RX || y >= RY) begin
        rec.care = 1'b1;
      end else begin
        rec.care = rknown[m_front][y][x];
        rec.val = rmem[m_front][y][x];
      end
    end
    if (do_wr && rdyc) begin
      if (tile >= TC) m_oob = 1'b1;
      else model_write(tile, data, mask);
    end
    if (do_sw && rdyc) begin
      m_front = m_back;
      m_back = (m_back + 1) % NB;
      m_count = (m_count + 1) % 65536;
      sd_q.push_back(cyc + LAT);
      if (AC) begin
        busy_until = cyc + TC;
        model_clear(m_back);
      end
    end
    rec.front = m_front;
    rec.cnt = m_count;
    rec.oob = m_oob;
    rec.rdy = (cyc + 1) > busy_until;
    sb.push_back(rec);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int x, input int y);
    step(0, 0, '0, '0, 1, x, y, 0);
  endtask

  task automatic wr(input int t, input logic [127:0] d,
                    input logic [15:0] m);
    step(1, t, d, m, 0, 0, 0, 0);
  endtask

  task automatic sw();
    step(0, 0, '0, '0, 0, 0, 0, 1);
  endtask

  task automatic wait_ready();
    while ((cyc + 1) <= busy_until) idle(1);
  endtask

  logic [7:0] last_val;
  bit last_known;
  always @(negedge clk) begin
    exp_t r;
    bit sd_exp;
    if (reset) begin
      last_val = '0;
      last_known = 1'b1;
    end else if (chk_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r = sb.pop_front();
        check("rd_valid", int'(rd_valid), int'(r.rd));
        if (r.rd) begin
          if (r.care) check("rd_value", int'(rd_pxl_value), int'(r.val));
          last_val = r.val;
          last_known = r.care;
        end else if (last_known) begin
          check("rd_hold", int'(rd_pxl_value), int'(last_val));
        end
        check("front_idx", int'(front_idx), r.front);
        check("swap_count", int'(swap_count), r.cnt);
        check("wr_oob", int'(wr_oob), int'(r.oob));
        check("wr_ready", int'(wr_ready), int'(r.rdy));
        check("swap_ready", int'(swap_ready), int'(r.rdy));
      end
      sd_exp = sd_q.size() > 0 && sd_q[0] == cyc;
      if (sd_exp) void'(sd_q.pop_front());
      check("swap_done", int'(swap_done), int'(sd_exp));
    end
  end

  task automatic check_reset_outputs();
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_swap_ready", int'(swap_ready), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_value", int'(rd_pxl_value), 0);
    check("rst_swap_done", int'(swap_done), 0);
    check("rst_wr_oob", int'(wr_oob), 0);
    check("rst_front", int'(front_idx), 0);
    check("rst_swap_count", int'(swap_count), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    m_front = 0;
    m_back = 1;
    m_count = 0;
    m_oob = 1'b0;
    busy_until = cyc;
    @(negedge clk);
    check("post_rst_wr_ready", int'(wr_ready), 1);
    chk_en = 1'b1;
  endtask

  initial begin
    logic [127:0] d;
    int tl[8] = '{0, 1, 2, 3, 100, 101, 102, 103};
    int x, y;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    release_reset();

    for (int p = 0; p < 16; p++) d[p*8 +: 8] = 8'(p + 1);
    wr(0, d, 16'hFFFF);
    sw();
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) rd(xx, yy);
    wait_ready();

    wr(101, {16{8'h55}}, 16'hFFFF);
    wr(101, {16{8'hAA}}, 16'h0001);
    sw();
    rd(4, 4);
    rd(5, 4);
    rd(400, 0);
    rd(0, 300);
    wait_ready();

    wr(7500, {16{8'h77}}, 16'hFFFF);
    idle(2);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0, 1, 4, 4, 1);
      rd(5, 4);
      wait_ready();
    end

    for (int t = 0; t < 200; t++) wr(t, {16{8'hFF}}, 16'hFFFF);
    sw();
    wr(0, {16{8'h11}}, 16'hFFFF);
    wait_ready();
    sw();
    wait_ready();
    for (int i = 0; i < 200; i++) begin
      x = int'($urandom_range(RX - 1));
      y = int'($urandom_range(RY - 1));
      rd(x, y);
    end

    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 4; p++) d[p*32 +: 32] = $urandom;
      x = int'($urandom % 16);
      y = int'($urandom % 8);
      if ($urandom % 20 == 0) x = RX + int'($urandom % 100);
      if ($urandom % 20 == 0) y = RY + int'($urandom % 100);
      step($urandom % 3 == 0, tl[$urandom % 8], d,
           ($urandom % 2 == 0) ? 16'hFFFF : 16'($urandom),
           $urandom % 2 == 0, x, y, $urandom % 150 == 0);
    end
    idle(3);
    wait_ready();

    sw();
    idle(50);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b0;
    wr_valid = 1'b0;
    rd_en = 1'b0;
    swap_req = 1'b0;
    sb.delete();
    sd_q.delete();
    @(negedge clk);
    check_reset_outputs();
    release_reset();
    idle(10);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
